// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with stall, branch redirect, exception
// entry and exception return.
//
// A redirect or exception return that arrives while the pipeline is stalled
// is held in a single pending slot. It is applied on the next cycle where
// wpc=1, unless a newer request arrives first. Exceptions ignore the stall.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   wpc           update enable (0 = stall, hold pc)
//   redir         branch/jump redirect request
//   redir_target  redirect destination
//   exc           exception request (highest priority, ignores wpc)
//   exc_pc        pc of the faulting instruction, captured into epc
//   eret          exception return request (target is epc)
//   pc            current fetch pc (registered)
//   pc_next_seq   pc + INC (combinational)
//   epc           saved exception pc (registered)
//   pend          a redirect is pending because of a stall (registered)
//   misalign      pc[1:0] != 0 (combinational, informational only)
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_RUN  | no redirect pending; wpc=1 advances pc sequentially
// ST_PEND | a stalled redirect/eret target waits in pend_tgt

module pc_unit #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
   parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_0180,
   parameter int unsigned      INC       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wpc,
   input  logic             redir,
   input  logic [WIDTH-1:0] redir_target,
   input  logic             exc,
   input  logic [WIDTH-1:0] exc_pc,
   input  logic             eret,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_next_seq,
   output logic [WIDTH-1:0] epc,
   output logic             pend,
   output logic             misalign
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] pend_tgt;
   logic [WIDTH-1:0] req_tgt;

   // eret outranks redir when both are raised together.
   assign req_tgt     = eret ? epc : redir_target;

   // Modulo 2^WIDTH by truncation; no overflow indication.
   assign pc_next_seq = pc + WIDTH'(INC);
   assign misalign    = |pc[1:0];

   // pend is a direct decode of the single state flop.
   assign pend        = (state == ST_PEND);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_VEC;
         epc      <= '0;
         pend_tgt <= '0;
         state    <= ST_RUN;
      end else if (exc) begin
         pc    <= EXC_VEC;
         epc   <= exc_pc;
         state <= ST_RUN;
      end else if (eret || redir) begin
         if (wpc) begin
            // A fresh request supersedes anything already pending.
            pc    <= req_tgt;
            state <= ST_RUN;
         end else begin
            // Latest stalled request overwrites the pending slot.
            pend_tgt <= req_tgt;
            state    <= ST_PEND;
         end
      end else if (wpc) begin
         if (state == ST_PEND) begin
            pc <= pend_tgt;
         end else begin
            pc <= pc_next_seq;
         end
         state <= ST_RUN;
      end
   end

endmodule
